// File: rtl/kbd_pkg.sv
// Shared keyboard-link definitions used by intel8042 and xt_kbd_receiver.
package kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_HUNT
  } kbd_state_e;

  localparam int unsigned KBD_START_CYCLES = 2;
  localparam int unsigned KBD_DATA_BITS    = 8;
  localparam logic        KBD_IDLE_LEVEL   = 1'b1;

endpackage

// File: rtl/kbd_sync2.sv
// Two-flop synchronizer for the keyboard data line; flops reset to the idle level.
// Only compiled when KBD_RX_SYNC_EN is defined, since nothing else instantiates it.
`ifdef KBD_RX_SYNC_EN
module kbd_sync2
  import kbd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= KBD_IDLE_LEVEL;
      sync_q <= KBD_IDLE_LEVEL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`endif

// File: rtl/xt_kbd_receiver.sv
// Receiver for the 8042 serial scan-code stream: deserializer, holding register, IRQ1 flag.
// Define KBD_RX_SYNC_EN to insert a two-flop synchronizer (adds 2 cycles of latency).
module xt_kbd_receiver
  import kbd_pkg::*;
#(
  parameter int unsigned START_CYCLES = KBD_START_CYCLES,
  parameter int unsigned DATA_BITS    = KBD_DATA_BITS
) (
  input  logic                 KBD_CLK,
  input  logic                 KBD_RESET_N,
  input  logic                 KBD_DATA,
  input  logic                 CLR,
  output logic [DATA_BITS-1:0] SCAN_CODE,
  output logic                 IRQ,
  output logic                 OVERRUN,
  output logic                 FRAME_ERR
);

  localparam int unsigned CNT_W = $clog2(START_CYCLES + 1);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic line;

`ifdef KBD_RX_SYNC_EN
  kbd_sync2 u_sync (
    .clk   (KBD_CLK),
    .rst_n (KBD_RESET_N),
    .d     (KBD_DATA),
    .q     (line)
  );
`else
  assign line = KBD_DATA;
`endif

  kbd_state_e           state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [IDX_W-1:0]     idx_d, idx_q;
  logic [DATA_BITS-1:0] shreg_d, shreg_q;
  logic [DATA_BITS-1:0] code_d, code_q;
  logic                 irq_d, irq_q;
  logic                 ovr_d, ovr_q;
  logic                 ferr_d, ferr_q;
  logic                 accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    code_d  = code_q;
    irq_d   = irq_q;
    ovr_d   = ovr_q;
    ferr_d  = ferr_q;
    accept  = 1'b0;

    if (CLR) begin
      irq_d  = 1'b0;
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!line) begin
          if (START_CYCLES <= 1) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_START;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_START: begin
        if (line) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_LAST) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
      end
      ST_DATA: begin
        shreg_d[idx_q] = line;
        if (idx_q == IDX_LAST) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_STOP: begin
        if (line) begin
          accept  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = ST_HUNT;
        end
      end
      ST_HUNT: begin
        if (line) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // An acknowledge landing on the accept edge frees the holding register for the new byte.
    if (accept) begin
      if (irq_q && !CLR) begin
        ovr_d = 1'b1;
      end else begin
        code_d = shreg_q;
        irq_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge KBD_CLK or negedge KBD_RESET_N) begin
    if (!KBD_RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      code_q  <= '0;
      irq_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      code_q  <= code_d;
      irq_q   <= irq_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign SCAN_CODE = code_q;
  assign IRQ       = irq_q;
  assign OVERRUN   = ovr_q;
  assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_xt_kbd_receiver.sv
// Self-checking bench for xt_kbd_receiver: table of frames plus reset, glitch and CLR sequences.
module tb_xt_kbd_receiver;

`ifdef KBD_RX_SYNC_EN
  localparam int unsigned EXTRA = 2;
`else
  localparam int unsigned EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kbd_data;
  logic       clr;
  logic [7:0] scan_code;
  logic       irq;
  logic       overrun;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xt_kbd_receiver #(
    .START_CYCLES (2),
    .DATA_BITS    (8)
  ) dut (
    .KBD_CLK     (clk),
    .KBD_RESET_N (rst_n),
    .KBD_DATA    (kbd_data),
    .CLR         (clr),
    .SCAN_CODE   (scan_code),
    .IRQ         (irq),
    .OVERRUN     (overrun),
    .FRAME_ERR   (frame_err)
  );

  typedef struct {
    logic [7:0]  b;
    logic        stop;
    int unsigned gap;
    logic        clr_before;
    logic        clr_acc;
    logic        pre_irq;
    logic [7:0]  code;
    logic        irq;
    logic        ovr;
    logic        ferr;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called #1 after edge N; start begins now, stop is sampled by the FSM at N+11+EXTRA.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic clr_acc,
                            output logic pre_irq);
    kbd_data = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      kbd_data = b[i];
      tick();
    end
    kbd_data = stop;
    repeat (EXTRA) tick();
    pre_irq = irq;
    clr = clr_acc;
    tick();
    clr = 1'b0;
    if (!stop) repeat (3) tick();
    kbd_data = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic pre;

    //          b      stop gap clrb clra pre   code   irq  ovr  ferr
    vecs[0] = '{8'h1C, 1'b1, 3, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h9C, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hAA, 1'b1, 3, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h3A, 1'b0, 3, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h3A, 1'b1, 3, 1'b0, 1'b0, 1'b0, 8'h3A, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h55, 1'b1, 3, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 1'b1, 3, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};

    rst_n    = 1'b0;
    kbd_data = 1'b1;
    clr      = 1'b0;
    repeat (3) tick();
    chk("rst_code", scan_code, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    rst_n = 1'b1;
    repeat (4) tick();

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_idle_irq", irq, 1'b0);
    chk("clr_idle_code", scan_code, 8'h00);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].clr_before) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
      end
      repeat (vecs[v].gap) tick();
      send_frame(vecs[v].b, vecs[v].stop, vecs[v].clr_acc, pre);
      chk($sformatf("v%0d_pre_irq", v), pre, vecs[v].pre_irq);
      chk($sformatf("v%0d_code", v), scan_code, vecs[v].code);
      chk($sformatf("v%0d_irq", v), irq, vecs[v].irq);
      chk($sformatf("v%0d_ovr", v), overrun, vecs[v].ovr);
      chk($sformatf("v%0d_ferr", v), frame_err, vecs[v].ferr);
    end

    clr = 1'b1;
    chk("clr_before_edge_irq", irq, 1'b1);
    tick();
    clr = 1'b0;
    chk("clr_irq", irq, 1'b0);
    chk("clr_ovr", overrun, 1'b0);
    chk("clr_code_kept", scan_code, 8'h00);

    tick();
    kbd_data = 1'b0;
    tick();
    kbd_data = 1'b1;
    repeat (4) tick();
    chk("glitch_irq", irq, 1'b0);
    chk("glitch_ferr", frame_err, 1'b0);
    chk("glitch_ovr", overrun, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0, pre);
    chk("glitch_next_code", scan_code, 8'h55);
    chk("glitch_next_irq", irq, 1'b1);

    repeat (2) tick();
    kbd_data = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      kbd_data = 1'b1;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_code", scan_code, 8'h00);
    chk("midrst_irq", irq, 1'b0);
    chk("midrst_ovr", overrun, 1'b0);
    chk("midrst_ferr", frame_err, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    send_frame(8'h01, 1'b1, 1'b0, pre);
    chk("post_rst_pre_irq", pre, 1'b0);
    chk("post_rst_code", scan_code, 8'h01);
    chk("post_rst_irq", irq, 1'b1);
    chk("post_rst_ovr", overrun, 1'b0);
    chk("post_rst_ferr", frame_err, 1'b0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
